// File: rtl/pwm_deadtime_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_deadtime_gen
// Description : Complementary gate-drive generator for one inverter leg.
//               Compares a triangle carrier against a double-buffered duty
//               value and produces a high-side / low-side command pair with
//               programmable dead time inserted on every commutation edge.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1    system clock
//   rst_n        in   1    synchronous active-low reset
//   carrier      in   CW   triangle carrier value
//   carrier_high in   1    carrier is at its peak
//   carrier_low  in   1    carrier is at zero
//   duty         in   CW   requested duty compare value
//   deadtime     in   DTW  dead time in clk cycles (sampled on DT entry)
//   update_both  in   1    1: shadow loads at peak and valley, 0: valley only
//   enable       in   1    leg enable
//   sw_hi        out  1    high-side gate command
//   sw_lo        out  1    low-side gate command
//   duty_active  out  CW   compare value currently in use
//   busy_dt      out  1    leg is inside a dead-time interval
// ============================================================================
module pwm_deadtime_gen #(
    parameter int CW  = 16,
    parameter int DTW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [CW-1:0]  carrier,
    input  logic           carrier_high,
    input  logic           carrier_low,
    input  logic [CW-1:0]  duty,
    input  logic [DTW-1:0] deadtime,
    input  logic           update_both,
    input  logic           enable,
    output logic           sw_hi,
    output logic           sw_lo,
    output logic [CW-1:0]  duty_active,
    output logic           busy_dt
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_LO    = 3'd1,
        S_DT_HI = 3'd2,
        S_HI    = 3'd3,
        S_DT_LO = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [DTW-1:0] r_cnt;
    logic [DTW-1:0] w_cnt_nxt;
    logic           w_ref;
    logic           w_shadow_load;

    // Compare uses the value already in the shadow register; a load in the
    // same cycle only becomes visible after this edge.
    assign w_ref = (carrier < duty_active);

    // While disabled the shadow simply tracks the request so that enabling
    // starts from the latest duty without waiting for a carrier extreme.
    assign w_shadow_load = !enable || carrier_low || (carrier_high && update_both);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_active <= '0;
        end else if (w_shadow_load) begin
            duty_active <= duty;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!enable) begin
            w_state_nxt = S_OFF;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_nxt = w_ref ? S_DT_HI : S_DT_LO;
                    w_cnt_nxt   = deadtime;
                end
                S_LO: begin
                    if (w_ref) begin
                        w_state_nxt = S_DT_HI;
                        w_cnt_nxt   = deadtime;
                    end
                end
                S_DT_HI: begin
                    // Falling back is safe: the high side never turned on.
                    if (!w_ref) begin
                        w_state_nxt = S_LO;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = S_HI;
                    end else begin
                        w_cnt_nxt = r_cnt - DTW'(1);
                    end
                end
                S_HI: begin
                    if (!w_ref) begin
                        w_state_nxt = S_DT_LO;
                        w_cnt_nxt   = deadtime;
                    end
                end
                S_DT_LO: begin
                    if (w_ref) begin
                        w_state_nxt = S_HI;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = S_LO;
                    end else begin
                        w_cnt_nxt = r_cnt - DTW'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_OFF;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state and are glitch-free at the pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            sw_hi   <= 1'b0;
            sw_lo   <= 1'b0;
            busy_dt <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            sw_hi   <= (w_state_nxt == S_HI);
            sw_lo   <= (w_state_nxt == S_LO);
            busy_dt <= (w_state_nxt == S_DT_HI) || (w_state_nxt == S_DT_LO);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_deadtime_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_deadtime_gen
// Description : Self-checking bench for pwm_deadtime_gen. A behavioural model
//               of the leg (which side is on, pending dead-time gap, shadow
//               duty) is advanced every clock and compared to the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_deadtime_gen;

    localparam int CW  = 16;
    localparam int DTW = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [CW-1:0]  carrier;
    logic           carrier_high;
    logic           carrier_low;
    logic [CW-1:0]  duty;
    logic [DTW-1:0] deadtime;
    logic           update_both;
    logic           enable;
    logic           sw_hi;
    logic           sw_lo;
    logic [CW-1:0]  duty_active;
    logic           busy_dt;

    pwm_deadtime_gen #(.CW(CW), .DTW(DTW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .carrier      (carrier),
        .carrier_high (carrier_high),
        .carrier_low  (carrier_low),
        .duty         (duty),
        .deadtime     (deadtime),
        .update_both  (update_both),
        .enable       (enable),
        .sw_hi        (sw_hi),
        .sw_lo        (sw_lo),
        .duty_active  (duty_active),
        .busy_dt      (busy_dt)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_hi, m_lo, m_gap, m_to_hi;
    int          m_left;
    logic [CW-1:0] m_da;

    task automatic model_tick();
        bit r;
        if (!rst_n) begin
            m_hi = 0; m_lo = 0; m_gap = 0; m_left = 0; m_da = '0;
            return;
        end
        r = (int'(carrier) < int'(m_da));
        if (!enable) begin
            m_hi = 0; m_lo = 0; m_gap = 0; m_left = 0;
        end else if (m_hi) begin
            if (!r) begin m_hi = 0; m_gap = 1; m_to_hi = 0; m_left = int'(deadtime); end
        end else if (m_lo) begin
            if (r) begin m_lo = 0; m_gap = 1; m_to_hi = 1; m_left = int'(deadtime); end
        end else if (!m_gap) begin
            m_gap = 1; m_to_hi = r; m_left = int'(deadtime);
        end else if (r != m_to_hi) begin
            m_gap = 0; m_hi = r; m_lo = !r;
        end else if (m_left == 0) begin
            m_gap = 0; m_hi = m_to_hi; m_lo = !m_to_hi;
        end else begin
            m_left--;
        end
        if (!enable || carrier_low || (carrier_high && update_both)) m_da = duty;
    endtask

    // ---------------- triangle carrier ----------------
    int cmax   = 10;
    int car    = 0;
    bit up     = 1;
    bit tri_on = 1;

    task automatic drive_tri();
        carrier      = CW'(car);
        carrier_high = (car == cmax);
        carrier_low  = (car == 0);
    endtask

    task automatic adv_tri();
        if (up) begin
            if (car >= cmax) begin up = 0; car = car - 1; end
            else car = car + 1;
        end else begin
            if (car == 0) begin up = 1; car = car + 1; end
            else car = car - 1;
        end
    endtask

    // gap-length tracking (both-off run between two on phases)
    int gap     = 0;
    bit seen_on = 0;
    int gap_exp = 0;

    task automatic gap_reset(input int e);
        gap = 0; seen_on = 0; gap_exp = e;
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        chk("sw_hi", sw_hi, m_hi);
        chk("sw_lo", sw_lo, m_lo);
        chk("busy_dt", busy_dt, m_gap);
        chk("duty_active", duty_active, m_da);
        chk("exclusive", sw_hi & sw_lo, 0);
        if (!sw_hi && !sw_lo) begin
            gap++;
        end else begin
            if (gap_exp != 0 && seen_on && gap != 0) chk("gap_len", gap, gap_exp);
            gap = 0;
            seen_on = 1;
        end
        if (tri_on) begin adv_tri(); drive_tri(); end
    endtask

    int cnt;

    initial begin
        rst_n = 0; duty = '0; deadtime = '0; update_both = 0; enable = 0;
        car = 0; up = 1; drive_tri();
        repeat (3) step();
        chk("rst_hi", sw_hi, 0);
        chk("rst_lo", sw_lo, 0);
        chk("rst_busy", busy_dt, 0);
        chk("rst_da", duty_active, 0);

        // 1: basic triangle, duty 4, dead time 2 -> 3 both-off cycles
        rst_n = 1; duty = 4; deadtime = 2; enable = 1;
        gap_reset(3);
        repeat (60) step();

        // 2: shadow timing, valley only
        for (int i = 0; i < 40 && !(car == 6 && up); i++) step();
        duty = 8;
        for (int i = 0; i < 40 && !carrier_low; i++) step();
        chk("shadow_hold", duty_active, 4);
        step();
        chk("shadow_valley", duty_active, 8);
        // shadow timing, peak and valley
        update_both = 1;
        for (int i = 0; i < 40 && !(car == 6 && up); i++) step();
        duty = 3;
        for (int i = 0; i < 40 && !carrier_high; i++) step();
        chk("shadow_hold2", duty_active, 8);
        step();
        chk("shadow_peak", duty_active, 3);
        update_both = 0;
        gap_reset(0);

        // 3: limits
        duty = 0;
        repeat (40) step();
        for (int i = 0; i < 30; i++) begin
            step();
            chk("duty0_lo", sw_lo, 1);
            chk("duty0_hi", sw_hi, 0);
        end
        duty = 11;
        repeat (25) step();
        for (int i = 0; i < 30; i++) begin
            step();
            chk("dutymax_hi", sw_hi, 1);
            chk("dutymax_busy", busy_dt, 0);
        end

        // 4: dead-time abort under direct carrier control
        tri_on = 0;
        duty = 5; deadtime = 2; carrier = 9; carrier_high = 0; carrier_low = 1;
        step();
        carrier_low = 0;
        repeat (10) step();
        chk("abort_pre_lo", sw_lo, 1);
        deadtime = 5; carrier = 0;
        cnt = 0;
        step(); cnt += int'(busy_dt); chk("abort_hi0", sw_hi, 0);
        step(); cnt += int'(busy_dt); chk("abort_hi1", sw_hi, 0);
        carrier = 9;
        for (int i = 0; i < 8; i++) begin
            step();
            cnt += int'(busy_dt);
            chk("abort_hi", sw_hi, 0);
            if (i == 0) chk("abort_lo_back", sw_lo, 1);
        end
        chk("abort_busy_len", cnt, 2);

        // 5: zero dead time, then mid-count dead-time change
        tri_on = 1; car = 0; up = 1; drive_tri();
        duty = 4; deadtime = 0;
        repeat (30) step();
        gap_reset(1);
        repeat (50) step();
        deadtime = 2;
        gap_reset(0);
        repeat (30) step();
        gap_reset(3);
        for (int i = 0; i < 60; i++) begin
            step();
            deadtime = (!sw_hi && !sw_lo) ? 8'd7 : 8'd2;
        end
        deadtime = 2;
        gap_reset(0);

        // 6: disable and reset behaviour
        for (int i = 0; i < 100 && !sw_hi; i++) step();
        chk("wait_hi", sw_hi, 1);
        enable = 0;
        step();
        chk("dis_hi", sw_hi, 0);
        chk("dis_lo", sw_lo, 0);
        enable = 1;
        for (int i = 0; i < 100 && !sw_hi; i++) step();
        chk("wait_hi2", sw_hi, 1);
        rst_n = 0;
        #3;
        chk("sync_rst_hi", sw_hi, 1);
        chk("sync_rst_da", duty_active, m_da);
        step();
        chk("rst_mid_hi", sw_hi, 0);
        chk("rst_mid_lo", sw_lo, 0);
        chk("rst_mid_busy", busy_dt, 0);
        chk("rst_mid_da", duty_active, 0);
        rst_n = 1;

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) duty = CW'($urandom_range(0, cmax + 2));
            if ($urandom_range(0, 24) == 0) deadtime = DTW'($urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0) update_both = ~update_both;
            enable = ($urandom_range(0, 99) != 0);
            rst_n  = ($urandom_range(0, 299) != 0);
            if (car == 0 && $urandom_range(0, 3) == 0) cmax = $urandom_range(4, 20);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
